// File: rtl/timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timer_irq_ctrl
// Description : Interrupt aggregator for the timer / watchdog event sources.
//               Latches single-cycle event pulses into pending bits, applies
//               per-source enables, tracks sticky overflows, counts irq
//               rising edges and drives one registered level interrupt.
//               Bus register window at BASE_ADDR (offsets in addr[7:0]):
//                 0x00 PENDING (R/W1C)  0x04 ENABLE (R/W)  0x08 STATUS (R)
//                 0x0C OVERFLOW (R/W1C) 0x10 IRQ_CNT (R, 16-bit)
//               Optional macro IRQ_EVCNT_EN adds 8-bit saturating per-source
//               event counters at 0x20 + 4*i, cleared by a hit read.
// Ports       : clk    bus clock
//               rst_n  synchronous active-low reset
//               addr   bus address          wdata  bus write data
//               we     write strobe         re     read strobe
//               rdata  registered read data
//               evt    event pulses (N_SRC bits, synchronous to clk)
//               irq    registered level interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module timer_irq_ctrl #(
    parameter int          N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             we,
    input  logic             re,
    output logic [31:0]      rdata,
    input  logic [N_SRC-1:0] evt,
    output logic             irq
);

    localparam logic [7:0] c_OFF_PENDING  = 8'h00;
    localparam logic [7:0] c_OFF_ENABLE   = 8'h04;
    localparam logic [7:0] c_OFF_STATUS   = 8'h08;
    localparam logic [7:0] c_OFF_OVERFLOW = 8'h0C;
    localparam logic [7:0] c_OFF_IRQ_CNT  = 8'h10;

    logic             w_hit;
    logic [7:0]       w_off;
    logic             w_rd;
    logic             w_wr_pend;
    logic             w_wr_en;
    logic             w_wr_ovf;
    logic [N_SRC-1:0] w_pend_clr;
    logic [N_SRC-1:0] w_ovf_clr;
    logic [N_SRC-1:0] w_ovf_set;
    logic [N_SRC-1:0] w_pend_next;
    logic [N_SRC-1:0] w_ovf_next;
    logic             w_irq_next;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_enable;
    logic [N_SRC-1:0] r_ovf;
    logic             r_irq;
    logic [15:0]      r_irq_cnt;
    logic [31:0]      r_rdata;

    assign w_hit     = (addr[31:8] == BASE_ADDR[31:8]);
    assign w_off     = addr[7:0];
    assign w_rd      = re & w_hit;
    assign w_wr_pend = we & w_hit & (w_off == c_OFF_PENDING);
    assign w_wr_en   = we & w_hit & (w_off == c_OFF_ENABLE);
    assign w_wr_ovf  = we & w_hit & (w_off == c_OFF_OVERFLOW);

    // Upper wdata bits beyond N_SRC are intentionally ignored.
    assign w_unused  = ^wdata;

    assign w_pend_clr  = w_wr_pend ? wdata[N_SRC-1:0] : '0;
    assign w_ovf_clr   = w_wr_ovf  ? wdata[N_SRC-1:0] : '0;

    // A new event always wins over a same-cycle W1C.
    assign w_pend_next = (r_pend & ~w_pend_clr) | evt;

    // An event landing on an already pending bit is an overflow, unless the
    // software is clearing that bit in the very same cycle (then the event
    // simply re-arms it and nothing was lost).
    assign w_ovf_set   = evt & r_pend & ~w_pend_clr;
    assign w_ovf_next  = (r_ovf & ~w_ovf_clr) | w_ovf_set;

    assign w_irq_next  = |(r_pend & r_enable);

`ifdef IRQ_EVCNT_EN
    logic [N_SRC-1:0]      w_evcnt_sel;
    logic [N_SRC-1:0][7:0] w_evcnt_val;
    logic                  w_evcnt_hit;
    logic [7:0]            w_evcnt_rd;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_evcnt
            logic [7:0] r_cnt;

            assign w_evcnt_sel[gi] = (w_off == 8'(32'h20 + 4 * gi));
            assign w_evcnt_val[gi] = r_cnt;

            // Read-to-clear; an event coinciding with the clearing read is
            // counted so it is not lost.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= 8'd0;
                end else if (w_rd && w_evcnt_sel[gi]) begin
                    r_cnt <= evt[gi] ? 8'd1 : 8'd0;
                end else if (evt[gi] && (r_cnt != 8'hFF)) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    endgenerate

    assign w_evcnt_hit = |w_evcnt_sel;

    always_comb begin
        w_evcnt_rd = 8'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_evcnt_sel[i]) begin
                w_evcnt_rd = w_evcnt_val[i];
            end
        end
    end
`endif

    // Read mux samples the current (pre-update) register contents.
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_off)
            c_OFF_PENDING:  w_rd_mux[N_SRC-1:0] = r_pend;
            c_OFF_ENABLE:   w_rd_mux[N_SRC-1:0] = r_enable;
            c_OFF_STATUS:   w_rd_mux[N_SRC-1:0] = r_pend & r_enable;
            c_OFF_OVERFLOW: w_rd_mux[N_SRC-1:0] = r_ovf;
            c_OFF_IRQ_CNT:  w_rd_mux[15:0]      = r_irq_cnt;
            default: begin
`ifdef IRQ_EVCNT_EN
                if (w_evcnt_hit) begin
                    w_rd_mux[7:0] = w_evcnt_rd;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend    <= '0;
            r_enable  <= '0;
            r_ovf     <= '0;
            r_irq     <= 1'b0;
            r_irq_cnt <= 16'd0;
            r_rdata   <= 32'd0;
        end else begin
            r_pend <= w_pend_next;
            r_ovf  <= w_ovf_next;
            r_irq  <= w_irq_next;
            if (w_wr_en) begin
                r_enable <= wdata[N_SRC-1:0];
            end
            if (w_irq_next && !r_irq) begin
                r_irq_cnt <= r_irq_cnt + 16'd1;
            end
            if (w_rd) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign rdata = r_rdata;
    assign irq   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_irq_ctrl
// Description : Self-checking bench for timer_irq_ctrl. A table of per-cycle
//               bus/event vectors with expected irq and read data, followed by
//               hand-written reset and event-counter sequences. Expected read
//               data is queued when a read is driven and compared when rdata
//               updates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_irq_ctrl;

    localparam int          N_SRC     = 8;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0100;

    logic             clk;
    logic             rst_n;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             we;
    logic             re;
    logic [31:0]      rdata;
    logic [N_SRC-1:0] evt;
    logic             irq;

    timer_irq_ctrl #(
        .N_SRC     (N_SRC),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .re    (re),
        .rdata (rdata),
        .evt   (evt),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        re;
        logic [7:0]  evt;
        logic        exp_irq;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_cmp;
    int          n_bad;

    function automatic logic [31:0] a(input logic [7:0] off);
        return BASE_ADDR + {24'd0, off};
    endfunction

    function automatic void add(input logic [31:0] ad, input logic w,
                                input logic [31:0] wd, input logic r,
                                input logic [7:0] ev, input logic ei,
                                input logic [31:0] er);
        vec_t v;
        v.addr = ad; v.we = w; v.wdata = wd; v.re = r;
        v.evt = ev; v.exp_irq = ei; v.exp_rd = er;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0; evt = '0; wdata = 32'd0;
    endtask

    task automatic rd(input logic [7:0] off, input logic [7:0] ev,
                      input logic [31:0] exp, input string name);
        addr = a(off); re = 1'b1; we = 1'b0; evt = ev;
        exp_q.push_back(exp);
        cyc();
        idle();
        check(name, rdata, exp_q.pop_front());
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        addr  = 32'd0;
        idle();

        // ----- table: enable, latency, W1C, overflow, read corners -----
        add(a(8'h04), 1, 32'h01, 0, 8'h00, 0, 0);    // ENABLE=1
        add(a(8'h00), 0, 0,      0, 8'h01, 0, 0);    // evt[0] at T
        add(a(8'h00), 0, 0,      0, 8'h00, 1, 0);    // irq at T+2
        add(a(8'h08), 0, 0,      1, 8'h00, 1, 32'h01);
        add(a(8'h10), 0, 0,      1, 8'h00, 1, 32'h01);
        add(a(8'h00), 0, 0,      1, 8'h00, 1, 32'h01);
        add(a(8'h00), 1, 32'h01, 0, 8'h00, 1, 0);    // W1C
        add(a(8'h00), 0, 0,      0, 8'h00, 0, 0);
        add(a(8'h00), 0, 0,      0, 8'h08, 0, 0);    // evt[3], disabled
        add(a(8'h00), 0, 0,      0, 8'h00, 0, 0);
        add(a(8'h00), 0, 0,      1, 8'h00, 0, 32'h08);
        add(a(8'h04), 1, 32'h08, 0, 8'h00, 0, 0);    // ENABLE=8
        add(a(8'h00), 0, 0,      0, 8'h00, 1, 0);
        add(a(8'h10), 0, 0,      1, 8'h00, 1, 32'h02);
        add(a(8'h00), 1, 32'h08, 0, 8'h00, 1, 0);
        add(a(8'h04), 1, 32'h01, 0, 8'h00, 0, 0);
        add(a(8'h00), 0, 0,      0, 8'h01, 0, 0);
        add(a(8'h00), 0, 0,      0, 8'h00, 1, 0);
        add(a(8'h00), 1, 32'h01, 0, 8'h01, 1, 0);    // set beats clear
        add(a(8'h00), 0, 0,      0, 8'h00, 1, 0);
        add(a(8'h0C), 0, 0,      1, 8'h00, 1, 32'h00);
        add(a(8'h00), 1, 32'h01, 0, 8'h00, 1, 0);
        add(a(8'h00), 0, 0,      0, 8'h00, 0, 0);
        add(a(8'h00), 0, 0,      0, 8'h04, 0, 0);    // evt[2] twice
        add(a(8'h00), 0, 0,      0, 8'h04, 0, 0);
        add(a(8'h0C), 0, 0,      1, 8'h00, 0, 32'h04);
        add(a(8'h0C), 1, 32'h04, 0, 8'h00, 0, 0);
        add(a(8'h0C), 0, 0,      1, 8'h00, 0, 32'h00);
        add(a(8'h00), 0, 0,      1, 8'h00, 0, 32'h04);
        add(a(8'h04), 1, 32'hFF, 1, 8'h00, 0, 32'h01); // read old, write new
        add(a(8'h04), 0, 0,      1, 8'h00, 1, 32'hFF);
        add(a(8'h10), 0, 0,      1, 8'h00, 1, 32'h04);
        add(32'h0000_0200, 0, 0, 1, 8'h00, 1, 32'h04); // miss: rdata holds
        add(a(8'h14), 0, 0,      1, 8'h00, 1, 32'h00); // unmapped
        add(32'h0000_0204, 1, 0, 0, 8'h00, 1, 0);      // miss write dropped
        add(a(8'h04), 0, 0,      1, 8'h00, 1, 32'hFF);
        add(a(8'h04), 1, 32'hFFFF_FFFF, 0, 8'h00, 1, 0);
        add(a(8'h04), 0, 0,      1, 8'h00, 1, 32'hFF);
        add(a(8'h08), 0, 0,      1, 8'h00, 1, 32'h04);
        add(a(8'h00), 0, 0,      1, 8'h20, 1, 32'h04); // pre-update value
        add(a(8'h00), 0, 0,      1, 8'h00, 1, 32'h24);

        // ----- reset state -----
        cyc();
        cyc();
        rst_n = 1'b1;
        check("reset irq", {31'd0, irq}, 32'd0);
        check("reset rdata", rdata, 32'd0);

        foreach (vecs[k]) begin
            addr  = vecs[k].addr;
            we    = vecs[k].we;
            wdata = vecs[k].wdata;
            re    = vecs[k].re;
            evt   = vecs[k].evt;
            if (vecs[k].re) exp_q.push_back(vecs[k].exp_rd);
            cyc();
            check($sformatf("vec%0d irq", k), {31'd0, irq},
                  {31'd0, vecs[k].exp_irq});
            if (vecs[k].re)
                check($sformatf("vec%0d rdata", k), rdata, exp_q.pop_front());
        end
        idle();

        // ----- reset mid-operation with an event during reset -----
        evt = 8'hFF;
        cyc();
        idle();
        cyc();
        check("pre-reset irq", {31'd0, irq}, 32'd1);
        rd(8'h0C, 8'h00, 32'h24, "pre-reset OVERFLOW");
        rd(8'h00, 8'h00, 32'hFF, "pre-reset PENDING");
        rst_n = 1'b0;
        evt   = 8'h10;
        cyc();
        rst_n = 1'b1;
        evt   = '0;
        check("post-reset irq", {31'd0, irq}, 32'd0);
        check("post-reset rdata", rdata, 32'd0);
        cyc();
        check("post-reset irq+1", {31'd0, irq}, 32'd0);
        rd(8'h00, 8'h00, 32'h00, "post-reset PENDING");
        rd(8'h04, 8'h00, 32'h00, "post-reset ENABLE");
        rd(8'h08, 8'h00, 32'h00, "post-reset STATUS");
        rd(8'h0C, 8'h00, 32'h00, "post-reset OVERFLOW");
        rd(8'h10, 8'h00, 32'h00, "post-reset IRQ_CNT");

        // ----- per-source event counters -----
        for (int i = 0; i < 300; i++) begin
            evt = 8'h02;
            cyc();
        end
        evt = '0;
        cyc();
`ifdef IRQ_EVCNT_EN
        rd(8'h24, 8'h00, 32'hFF, "evcnt1 saturate");
        rd(8'h24, 8'h00, 32'h00, "evcnt1 read-clear");
        rd(8'h24, 8'h02, 32'h00, "evcnt1 read with evt");
        rd(8'h24, 8'h00, 32'h01, "evcnt1 evt beats clear");
        rd(8'h20, 8'h00, 32'h00, "evcnt0 idle");
`else
        rd(8'h24, 8'h00, 32'h00, "evcnt unmapped");
`endif
        rd(8'h00, 8'h00, 32'h02, "final PENDING");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Interrupt aggregator downstream of the timer, pulse-sync and watchdog stages; runs in the bus clock domain.
- Latches single-cycle event pulses into per-source pending bits: timer usec/msec/sec pulses and the synchronised watchdog timeout.
- Per-source enable masks, sticky overflow flags, a bus register interface, and a single registered interrupt line to the CPU.

Parameters:
- N_SRC, 8, number of event sources (1..32).
- BASE_ADDR, 32'h0000_0100, base address of the register window (bits [7:0] must be zero).

Ports:
- clk  input  1  bus clock.
- rst_n  input  1  reset: one clock; reset is synchronous and active-low.
- addr  input  32  bus address.
- wdata  input  32  bus write data.
- we  input  1  write strobe, one cycle per write.
- re  input  1  read strobe, one cycle per read.
- rdata  output  32  read data, registered.
- evt  input  N_SRC  event pulses, already synchronised to clk; each bit is 1 cycle high per event.
- irq  output  1  interrupt request, registered, level.

Behaviour:
- Register window: hit when addr[31:8] == BASE_ADDR[31:8]. Offsets are addr[7:0]. Bits >= N_SRC read 0 and ignore writes.
  - 0x00 PENDING: read; write-1-to-clear.
  - 0x04 ENABLE: read/write.
  - 0x08 STATUS: read-only, PENDING & ENABLE.
  - 0x0C OVERFLOW: read; write-1-to-clear.
  - 0x10 IRQ_CNT: read-only, 16-bit count of irq rising edges, wraps 0xFFFF->0.
  - Unmapped offsets read 0; writes to them are dropped.
- Pending update per bit i, every cycle: pend_next = (pend & ~(we_hit_0x00 & wdata[i])) | evt[i].
  - Set dominates clear in the same cycle.
- Overflow: ovf[i] sets when evt[i]=1 and pend[i] is already 1, unless that same cycle clears pend[i].
  - Sticky. W1C at 0x0C; a set in the same cycle dominates the clear.
- ENABLE write takes effect in the register the cycle after we.
- irq = registered |(pend & enable); it reflects state one cycle after the register update.
  - Latency evt -> irq is 2 cycles: cycle 0 evt, cycle 1 pend set, cycle 2 irq high.
- Read path:
  - re with hit: rdata loads the selected register at the next edge and holds until the next hit read.
  - Read of PENDING returns the pre-update value of that cycle.
  - re without hit: rdata holds.
  - re and we together at the same offset: the read returns the old value and the write applies.
- Reset (rst_n low at a clk edge): pend, enable, ovf, irq_cnt, rdata, irq all become 0.
  - Events arriving during reset are discarded.
  - Reset in mid-transaction aborts it; no partial state is kept.
- IRQ_CNT increments when the irq register goes 0->1.

Optional Feature:
- Macro IRQ_EVCNT_EN.
- Defined:
  - Adds per-source 8-bit saturating event counters at offset 0x20 + 4*i, value in bits [7:0].
  - A counter increments on evt[i] and stops at 0xFF.
  - A hit read (re) clears it to 0 the following cycle. An event in that same cycle loads it to 1, not 0.
  - Reset clears all counters.
- Undefined: offsets 0x20.. are unmapped and read 0. No counter flops are present.

Test Plan:
- Reset, then ENABLE=0x01, pulse evt[0] at cycle T -> pend[0]=1 at T+1, irq=1 at T+2, STATUS reads 0x01, IRQ_CNT=1.
- evt[3] with ENABLE=0 -> PENDING=0x08, irq stays 0. Then write ENABLE=0x08 -> irq=1 two cycles after we.
- Write 0x01 to PENDING in the same cycle evt[0] pulses -> pend[0] stays 1, irq stays 1. Next W1C alone -> irq drops 2 cycles later.
- Two evt[2] pulses without clearing -> OVERFLOW=0x04. W1C 0x04 to 0x0C -> OVERFLOW reads 0.
- Assert rst_n=0 for 1 cycle while pend=0xFF and irq=1 -> all registers and irq read 0. An evt during reset leaves PENDING=0.
- With IRQ_EVCNT_EN: 300 evt[1] pulses -> offset 0x24 reads 0xFF, a second read returns 0. Without the macro, 0x24 reads 0.
